// File: rtl/trace_stream_arbiter.sv
// Round-robin arbiter merging NUM_SOURCES AXI-Stream trace producers into one
// registered output stream; each beat carries the source index on m_axis_tid.
module trace_stream_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 1024,
    parameter int ID_WIDTH    = 3,
    parameter int BURST_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
    output logic [NUM_SOURCES-1:0]            s_axis_tready,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
    output logic                              M_AXIS_tvalid,
    input  logic                              M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]             M_AXIS_tdata,
    output logic                              M_AXIS_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_tid,
    input  logic [NUM_SOURCES-1:0]            source_enable,
    input  logic [BURST_WIDTH-1:0]            max_burst,
    output logic [ID_WIDTH-1:0]               grant_id,
    output logic                              busy
);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                 state;
    logic [ID_WIDTH-1:0]    last_grant;
    logic [ID_WIDTH-1:0]    winner;
    logic                   found;
    logic [NUM_SOURCES-1:0] cand;
    int unsigned            idx;
    int unsigned            gidx;
    logic [BURST_WIDTH-1:0] beat_cnt;
    logic [BURST_WIDTH-1:0] cnt_next;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   out_ready;
    logic                   accept;
    logic                   burst_hit;
    logic                   last_beat;

    // Rotating priority: first enabled requester after the previous winner.
    always_comb begin
        cand   = s_axis_tvalid & source_enable;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
            idx = (32'(last_grant) + i) % NUM_SOURCES;
            if (!found && |(cand & (NUM_SOURCES'(1) << idx))) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        gidx      = 32'(grant_id);
        sel_valid = |(s_axis_tvalid & (NUM_SOURCES'(1) << gidx));
        sel_last  = |(s_axis_tlast & (NUM_SOURCES'(1) << gidx));
        sel_data  = DATA_WIDTH'(s_axis_tdata >> (gidx * DATA_WIDTH));
        out_ready = ~M_AXIS_tvalid | M_AXIS_tready;
        accept    = (state == GRANTED) && sel_valid && out_ready;
        cnt_next  = beat_cnt + BURST_WIDTH'(1);
        burst_hit = (max_burst != '0) && (cnt_next == max_burst);
        last_beat = sel_last | burst_hit;
        s_axis_tready = (state == GRANTED) ? (NUM_SOURCES'(out_ready) << gidx) : '0;
    end

    assign busy = (state == GRANTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            grant_id      <= '0;
            beat_cnt      <= '0;
            last_grant    <= ID_WIDTH'(NUM_SOURCES - 1);
        end else begin
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANTED;
                        grant_id <= winner;
                        beat_cnt <= '0;
                    end
                end
                GRANTED: begin
                    if (accept) begin
                        M_AXIS_tvalid <= 1'b1;
                        M_AXIS_tdata  <= sel_data;
                        M_AXIS_tlast  <= last_beat;
                        m_axis_tid    <= grant_id;
                        // Saturating count; equality compare means a limit already passed never fires.
                        if (beat_cnt != '1) begin
                            beat_cnt <= cnt_next;
                        end
                        if (last_beat) begin
                            state      <= IDLE;
                            last_grant <= grant_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Directed scoreboard bench for trace_stream_arbiter: source beats are pushed as
// expectations on acceptance and popped when the output register delivers them.
module tb_trace_stream_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int BW = 16;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tready;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]    s_axis_tlast;
    logic             M_AXIS_tvalid;
    logic             M_AXIS_tready;
    logic [DW-1:0]    M_AXIS_tdata;
    logic             M_AXIS_tlast;
    logic [IW-1:0]    m_axis_tid;
    logic [NS-1:0]    source_enable;
    logic [BW-1:0]    max_burst;
    logic [IW-1:0]    grant_id;
    logic             busy;

    trace_stream_arbiter #(
        .NUM_SOURCES(NS),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .BURST_WIDTH(BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tlast (s_axis_tlast),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS_tdata (M_AXIS_tdata),
        .M_AXIS_tlast (M_AXIS_tlast),
        .m_axis_tid   (m_axis_tid),
        .source_enable(source_enable),
        .max_burst    (max_burst),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    typedef struct packed {
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW:0]   srcq [NS][$];
    beat_t         sb[$];
    logic [IW-1:0] log_tid[$];
    logic          log_last[$];
    int            log_cyc[$];
    logic [NS-1:0] hold;
    int            checks, fails, cyc, mcnt;
    logic          stalled;
    logic [DW-1:0] st_data;
    logic          st_last;
    logic [IW-1:0] st_tid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int src, input int pkt, input int beats);
        for (int b = 1; b <= beats; b++) begin
            srcq[src].push_back({(b == beats), 8'(src), 8'(pkt), 16'(b)});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() != 0 && !hold[i]) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*DW +: DW] = srcq[i][0][DW-1:0];
                s_axis_tlast[i]          = srcq[i][0][DW];
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic clear_log();
        log_tid.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    task automatic cycle();
        logic [NS-1:0] fire;
        logic [DW:0]   b;
        beat_t         e;
        logic          exp_last;
        @(negedge clk);
        fire = s_axis_tvalid & s_axis_tready;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                if (fire[i]) void'(srcq[i].pop_front());
            end
            sb.delete();
            mcnt    = 0;
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_data", M_AXIS_tdata, st_data);
                chk("hold_last", M_AXIS_tlast, st_last);
                chk("hold_tid", m_axis_tid, st_tid);
                chk("hold_valid", M_AXIS_tvalid, 1);
            end
            if (M_AXIS_tvalid && !M_AXIS_tready) chk("stall_src_ready", s_axis_tready, 0);
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", M_AXIS_tvalid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_tid", m_axis_tid, e.tid);
                    chk("out_data", M_AXIS_tdata, e.data);
                    chk("out_last", M_AXIS_tlast, e.last);
                end
                log_tid.push_back(m_axis_tid);
                log_last.push_back(M_AXIS_tlast);
                log_cyc.push_back(cyc);
            end
            stalled = M_AXIS_tvalid && !M_AXIS_tready;
            st_data = M_AXIS_tdata;
            st_last = M_AXIS_tlast;
            st_tid  = m_axis_tid;
            for (int i = 0; i < NS; i++) begin
                if (fire[i]) begin
                    b = srcq[i].pop_front();
                    exp_last = b[DW] | ((max_burst != 0) && (mcnt + 1 == int'(max_burst)));
                    sb.push_back('{tid: IW'(i), data: b[DW-1:0], last: exp_last});
                    mcnt = exp_last ? 0 : mcnt + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    function automatic int pending(input logic [NS-1:0] mask);
        int n = sb.size();
        for (int i = 0; i < NS; i++) if (mask[i]) n += srcq[i].size();
        return n;
    endfunction

    task automatic run_drain(input logic [NS-1:0] mask, input int budget);
        int n = 0;
        while ((pending(mask) != 0 || M_AXIS_tvalid) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_pending", pending(mask), 0);
    endtask

    task automatic run_until_logged(input int cnt, input int budget);
        int n = 0;
        while (log_tid.size() < cnt && n < budget) begin
            cycle();
            n++;
        end
        chk("log_reached", (log_tid.size() >= cnt), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, M_AXIS_tvalid, 0);
        chk({tag, "_tdata"}, M_AXIS_tdata, 0);
        chk({tag, "_tlast"}, M_AXIS_tlast, 0);
        chk({tag, "_tid"}, m_axis_tid, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sready"}, s_axis_tready, 0);
    endtask

    initial begin
        checks = 0; fails = 0; cyc = 0; mcnt = 0;
        stalled = 1'b0; st_data = '0; st_last = 1'b0; st_tid = '0;
        hold = '0;
        s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
        M_AXIS_tready = 1'b1; source_enable = '1; max_burst = '0;
        rst = 1'b1;
        cycle();
        cycle();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Round-robin over all sources, 2-beat packets, one bubble per grant.
        clear_log();
        for (int s = 0; s < NS; s++) begin
            load(s, 0, 2);
            load(s, 1, 2);
        end
        drive();
        run_drain('1, 200);
        chk("t1_count", log_tid.size(), 16);
        for (int k = 0; k < 16; k++) begin
            chk("t1_tid", log_tid[k], (k / 2) % 4);
            chk("t1_last", log_last[k], k % 2);
        end
        for (int k = 0; k < 15; k++) chk("t1_gap", log_cyc[k+1] - log_cyc[k], (k % 2 == 0) ? 1 : 2);

        // Burst limit 4 splits a 10-beat packet into 4,4,2.
        clear_log();
        max_burst = 16'd4;
        load(2, 2, 10);
        drive();
        run_drain('1, 200);
        chk("t2_count", log_tid.size(), 10);
        for (int k = 0; k < 10; k++) begin
            chk("t2_tid", log_tid[k], 2);
            chk("t2_last", log_last[k], (k == 3 || k == 7 || k == 9));
        end
        chk("t2_gap4", log_cyc[4] - log_cyc[3], 2);
        chk("t2_gap8", log_cyc[8] - log_cyc[7], 2);
        max_burst = '0;

        // Downstream back-pressure for three cycles in mid-packet.
        clear_log();
        load(1, 3, 6);
        drive();
        repeat (4) cycle();
        M_AXIS_tready = 1'b0;
        repeat (3) cycle();
        chk("t3_stall_valid", M_AXIS_tvalid, 1);
        chk("t3_stall_sready", s_axis_tready, 0);
        M_AXIS_tready = 1'b1;
        run_drain('1, 200);
        chk("t3_count", log_tid.size(), 6);

        // Enable mask 1010: only sources 1 and 3, alternating, starting after last grant 1.
        clear_log();
        source_enable = 4'b1010;
        load(0, 4, 2); load(2, 4, 2);
        load(1, 4, 3); load(1, 5, 3);
        load(3, 4, 3); load(3, 5, 3);
        drive();
        run_drain(4'b1010, 300);
        chk("t4_count", log_tid.size(), 12);
        for (int k = 0; k < 12; k++) chk("t4_tid", log_tid[k], ((k / 3) % 2 == 0) ? 3 : 1);
        chk("t4_src0_waiting", srcq[0].size(), 2);
        chk("t4_src2_waiting", srcq[2].size(), 2);

        // Disabling source 1 mid-packet lets that packet finish, then never re-grants it.
        clear_log();
        load(1, 6, 4);
        drive();
        run_until_logged(2, 50);
        source_enable = 4'b1000;
        load(3, 6, 2);
        load(1, 7, 2);
        drive();
        run_drain(4'b1000, 100);
        repeat (5) cycle();
        chk("t4b_count", log_tid.size(), 6);
        for (int k = 0; k < 6; k++) chk("t4b_tid", log_tid[k], (k < 4) ? 1 : 3);
        chk("t4b_src1_waiting", srcq[1].size(), 2);

        for (int s = 0; s < NS; s++) srcq[s].delete();
        drive();
        source_enable = '1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset_outputs("reset2");

        // Reset during beat 3 of a 6-beat packet; arbitration restarts at source 0.
        clear_log();
        load(1, 8, 6);
        drive();
        run_until_logged(2, 50);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        clear_log();
        load(0, 8, 2);
        drive();
        run_drain('1, 100);
        chk("t5_count", log_tid.size(), 4);
        chk("t5_first", log_tid[0], 0);
        chk("t5_second", log_tid[1], 0);
        chk("t5_third", log_tid[2], 1);
        chk("t5_remnant_last", log_last[3], 1);

        // Granted source 3 stalls for 5 cycles; source 0 must wait.
        clear_log();
        load(3, 9, 6);
        load(0, 9, 2);
        drive();
        run_until_logged(2, 50);
        hold[3] = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t6_busy", busy, 1);
            chk("t6_grant", grant_id, 3);
        end
        chk("t6_held_count", log_tid.size(), 3);
        hold[3] = 1'b0;
        drive();
        run_drain('1, 100);
        chk("t6_count", log_tid.size(), 8);
        for (int k = 0; k < 8; k++) chk("t6_tid", log_tid[k], (k < 6) ? 3 : 0);

        // Limit lowered below the running count: no forced tlast, source tlast ends grant.
        clear_log();
        max_burst = 16'd3;
        load(2, 10, 8);
        drive();
        run_until_logged(1, 50);
        max_burst = 16'd2;
        run_drain('1, 100);
        chk("t7_count", log_tid.size(), 8);
        for (int k = 0; k < 8; k++) chk("t7_last", log_last[k], (k == 7));
        max_burst = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
